// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: periodic multi-channel ADC scan; converts each enabled channel, scales to mV, stores per channel.
// Latency: per channel SELECT 1 + WAIT >=1 + STORE 1 + NEXT 1 cycles; adc_req/adc_addr/frame_done are registered.
// Backpressure: none; the ADC answers with an adc_valid pulse, and a missing answer times out after TIMEOUT cycles.
//
// Optional build macro ADC_SCAN_AVG_EN: each channel takes 4 conversions and stores the scaled average.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   enable, ch_mask       - scan allowed (sampled in IDLE), per-channel enable (latched at scan start)
//   adc_data, adc_valid   - conversion result and its one-cycle strobe
//   adc_addr, adc_req     - one-hot channel select (bit ADDR_SHIFT+ch) and one-cycle conversion request
//   ch_data, ch_fresh     - scaled results (channel k at [k*OUT_W +: OUT_W]) and per-frame update flags
//   frame_done, busy      - end-of-scan pulse, high outside IDLE
//   overrun, timeout_err  - sticky error flags, cleared only by rst
module adc_scan_sequencer #(
   parameter int N_CH       = 4,
   parameter int DATA_W     = 12,
   parameter int OUT_W      = 12,
   parameter int PERIOD     = 10_000_000,
   parameter int SCALE_NUM  = 805664,
   parameter int SCALE_DEN  = 1_000_000,
   parameter int ADDR_SHIFT = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic [N_CH-1:0]            ch_mask,
   input  logic [DATA_W-1:0]          adc_data,
   input  logic                       adc_valid,
   output logic [ADDR_SHIFT+N_CH-1:0] adc_addr,
   output logic                       adc_req,
   output logic [N_CH*OUT_W-1:0]      ch_data,
   output logic [N_CH-1:0]            ch_fresh,
   output logic                       frame_done,
   output logic                       busy,
   output logic                       overrun,
   output logic                       timeout_err
);

   localparam int AW     = ADDR_SHIFT + N_CH;
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int PC_W   = $clog2(PERIOD);
   localparam int WC_W   = $clog2(TIMEOUT + 1);
`ifdef ADC_SCAN_AVG_EN
   localparam int ACC_W  = DATA_W + 2;
`else
   localparam int ACC_W  = DATA_W;
`endif
   localparam int PROD_W = DATA_W + 32;
   localparam logic [AW-1:0]    ADDR_RST = AW'(1) << ADDR_SHIFT;
   localparam logic [OUT_W-1:0] OUT_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_WAIT,
      S_STORE,
      S_NEXT
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   per_cnt_q, per_cnt_d;
   logic [N_CH-1:0]   mask_q, mask_d;
   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [AW-1:0]     adc_addr_q, adc_addr_d;
   logic              adc_req_q, adc_req_d;
   logic [OUT_W-1:0]  ch_data_q [N_CH];
   logic [OUT_W-1:0]  ch_data_d [N_CH];
   logic [N_CH-1:0]   ch_fresh_q, ch_fresh_d;
   logic              frame_done_q, frame_done_d;
   logic              overrun_q, overrun_d;
   logic              timeout_q, timeout_d;
`ifdef ADC_SCAN_AVG_EN
   logic [1:0]        smp_q, smp_d;
`endif

   logic              start_evt;
   logic              scan_go;
   logic              wait_expired;
   logic [CH_W-1:0]   cur_ch;
   logic              more_ch;
   logic [DATA_W-1:0] store_raw;
   logic [PROD_W-1:0] prod;
   logic [PROD_W-1:0] quot;
   logic [OUT_W-1:0]  scaled;

   // Channel selection helpers: cur_ch is the lowest enabled channel at or
   // above the pointer, more_ch says whether anything above the pointer remains.
   always_comb begin
      start_evt    = (per_cnt_q == PC_W'(PERIOD - 1));
      scan_go      = start_evt && enable && (ch_mask != '0);
      wait_expired = (wait_cnt_q == WC_W'(TIMEOUT - 1));
      cur_ch       = ptr_q;
      more_ch      = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (mask_q[i] && (i >= int'(ptr_q))) cur_ch = CH_W'(i);
      end
      for (int i = 0; i < N_CH; i++) begin
         if (mask_q[i] && (i > int'(ptr_q))) more_ch = 1'b1;
      end
   end

`ifdef ADC_SCAN_AVG_EN
   assign store_raw = acc_q[ACC_W-1:2];
`else
   assign store_raw = acc_q;
`endif

   // Full-precision product, truncating divide, then saturate to the output width.
   assign prod   = PROD_W'(store_raw) * PROD_W'(SCALE_NUM);
   assign quot   = prod / PROD_W'(SCALE_DEN);
   assign scaled = (quot > PROD_W'(OUT_MAX)) ? OUT_MAX : quot[OUT_W-1:0];

   // State register (and all other flops)
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         per_cnt_q    <= '0;
         mask_q       <= '0;
         ptr_q        <= '0;
         wait_cnt_q   <= '0;
         acc_q        <= '0;
         adc_addr_q   <= ADDR_RST;
         adc_req_q    <= 1'b0;
         for (int k = 0; k < N_CH; k++) ch_data_q[k] <= '0;
         ch_fresh_q   <= '0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         timeout_q    <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
         smp_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         per_cnt_q    <= per_cnt_d;
         mask_q       <= mask_d;
         ptr_q        <= ptr_d;
         wait_cnt_q   <= wait_cnt_d;
         acc_q        <= acc_d;
         adc_addr_q   <= adc_addr_d;
         adc_req_q    <= adc_req_d;
         ch_data_q    <= ch_data_d;
         ch_fresh_q   <= ch_fresh_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
         timeout_q    <= timeout_d;
`ifdef ADC_SCAN_AVG_EN
         smp_q        <= smp_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (scan_go) state_d = S_SELECT;
         S_SELECT: state_d = S_WAIT;
         S_WAIT: begin
            // A valid arriving on the timeout cycle still wins.
            if (adc_valid) begin
`ifdef ADC_SCAN_AVG_EN
               state_d = (smp_q == 2'd3) ? S_STORE : S_SELECT;
`else
               state_d = S_STORE;
`endif
            end else if (wait_expired) begin
               state_d = S_NEXT;
            end
         end
         S_STORE:  state_d = S_NEXT;
         S_NEXT:   state_d = more_ch ? S_SELECT : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output and datapath logic
   always_comb begin
      per_cnt_d    = (per_cnt_q == PC_W'(PERIOD - 1)) ? '0 : per_cnt_q + PC_W'(1);
      mask_d       = mask_q;
      ptr_d        = ptr_q;
      wait_cnt_d   = wait_cnt_q;
      acc_d        = acc_q;
      adc_addr_d   = adc_addr_q;
      adc_req_d    = 1'b0;
      ch_data_d    = ch_data_q;
      ch_fresh_d   = ch_fresh_q;
      frame_done_d = 1'b0;
      // A scan that runs into the next start event is flagged, not restarted.
      overrun_d    = overrun_q | (start_evt && (state_q != S_IDLE));
      timeout_d    = timeout_q;
`ifdef ADC_SCAN_AVG_EN
      smp_d        = smp_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (scan_go) begin
               mask_d     = ch_mask;
               ptr_d      = '0;
               ch_fresh_d = '0;
               acc_d      = '0;
`ifdef ADC_SCAN_AVG_EN
               smp_d      = '0;
`endif
            end
         end
         S_SELECT: begin
            ptr_d      = cur_ch;
            adc_addr_d = ADDR_RST << cur_ch;
            adc_req_d  = 1'b1;
            wait_cnt_d = '0;
         end
         S_WAIT: begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
            if (adc_valid) begin
`ifdef ADC_SCAN_AVG_EN
               acc_d = acc_q + ACC_W'(adc_data);
               smp_d = smp_q + 2'd1;
`else
               acc_d = adc_data;
`endif
            end else if (wait_expired) begin
               // Channel abandoned: nothing stored, partial sums discarded.
               timeout_d = 1'b1;
               acc_d     = '0;
`ifdef ADC_SCAN_AVG_EN
               smp_d     = '0;
`endif
            end
         end
         S_STORE: begin
            ch_data_d[ptr_q]  = scaled;
            ch_fresh_d[ptr_q] = 1'b1;
            acc_d             = '0;
`ifdef ADC_SCAN_AVG_EN
            smp_d             = '0;
`endif
         end
         S_NEXT: begin
            ptr_d        = more_ch ? ptr_q + CH_W'(1) : '0;
            frame_done_d = !more_ch;
         end
         default: ;
      endcase
   end

   assign adc_addr    = adc_addr_q;
   assign adc_req     = adc_req_q;
   assign ch_fresh    = ch_fresh_q;
   assign frame_done  = frame_done_q;
   assign busy        = (state_q != S_IDLE);
   assign overrun     = overrun_q;
   assign timeout_err = timeout_q;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch_data
      assign ch_data[k*OUT_W +: OUT_W] = ch_data_q[k];
   end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed bench for adc_scan_sequencer with two instances
// (PERIOD=40/TIMEOUT=8 for functional frames, PERIOD=8 with slow ADC for overrun).
// Each instance has a small ADC responder answering a fixed number of cycles after adc_req.
`timescale 1ns/1ps
module tb_adc_scan_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 1 signals
   logic        rst1, enable1, adc_valid1, adc_req1, frame_done1, busy1, overrun1, timeout1;
   logic [3:0]  mask1, ch_fresh1;
   logic [11:0] adc_data1;
   logic [7:0]  adc_addr1;
   logic [47:0] ch_data1;

   // Instance 2 signals
   logic        rst2, enable2, adc_valid2, adc_req2, frame_done2, busy2, overrun2, timeout2;
   logic [3:0]  mask2, ch_fresh2;
   logic [11:0] adc_data2;
   logic [7:0]  adc_addr2;
   logic [47:0] ch_data2;

   adc_scan_sequencer #(.N_CH(4), .DATA_W(12), .OUT_W(12), .PERIOD(40), .TIMEOUT(8)) u_dut1 (
      .clk(clk), .rst(rst1), .enable(enable1), .ch_mask(mask1),
      .adc_data(adc_data1), .adc_valid(adc_valid1), .adc_addr(adc_addr1), .adc_req(adc_req1),
      .ch_data(ch_data1), .ch_fresh(ch_fresh1), .frame_done(frame_done1), .busy(busy1),
      .overrun(overrun1), .timeout_err(timeout1)
   );

   adc_scan_sequencer #(.N_CH(4), .DATA_W(12), .OUT_W(12), .PERIOD(8)) u_dut2 (
      .clk(clk), .rst(rst2), .enable(enable2), .ch_mask(mask2),
      .adc_data(adc_data2), .adc_valid(adc_valid2), .adc_addr(adc_addr2), .adc_req(adc_req2),
      .ch_data(ch_data2), .ch_fresh(ch_fresh2), .frame_done(frame_done2), .busy(busy2),
      .overrun(overrun2), .timeout_err(timeout2)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // ADC responder for instance 1: valid 3 cycles after req, code by channel.
   logic [11:0] code_tab [4];
   int          noans_ch;
   int          cnt1, pend1, dec_ch;
   initial begin
      cnt1 = 0; pend1 = 0; noans_ch = -1;
      adc_valid1 = 1'b0; adc_data1 = '0;
      forever begin
         @(negedge clk);
         adc_valid1 = 1'b0;
         if (cnt1 > 0) begin
            cnt1--;
            if (cnt1 == 0) begin
               adc_valid1 = 1'b1;
               adc_data1  = code_tab[pend1];
            end
         end
         if (adc_req1) begin
            dec_ch = 0;
            for (int k = 0; k < 4; k++) if (adc_addr1[4+k]) dec_ch = k;
            if (dec_ch != noans_ch) begin
               cnt1  = 3;
               pend1 = dec_ch;
            end
         end
      end
   end

   // ADC responder for instance 2: valid 5 cycles after req.
   int cnt2;
   initial begin
      cnt2 = 0;
      adc_valid2 = 1'b0; adc_data2 = 12'h123;
      forever begin
         @(negedge clk);
         adc_valid2 = 1'b0;
         if (cnt2 > 0) begin
            cnt2--;
            if (cnt2 == 0) adc_valid2 = 1'b1;
         end
         if (adc_req2) cnt2 = 5;
      end
   end

   // Event monitor for instance 1.
   int         cyc, fd_cnt, fd_cyc, rise_cyc;
   bit         busy_seen, busy_prev;
   logic [7:0] req_log [$];
   initial begin
      cyc = 0; fd_cnt = 0; fd_cyc = 0; rise_cyc = 0; busy_seen = 0; busy_prev = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (adc_req1) req_log.push_back(adc_addr1);
         if (frame_done1) begin
            fd_cnt++;
            fd_cyc = cyc;
         end
         if (busy1 && !busy_prev) rise_cyc = cyc;
         if (busy1) busy_seen = 1'b1;
         busy_prev = busy1;
      end
   end

   task automatic clear_log();
      req_log.delete();
      fd_cnt    = 0;
      busy_seen = 1'b0;
   endtask

   task automatic wait_frame(input int budget, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (frame_done1) seen = 1'b1;
      end
      check_val(tag, seen, 1);
      @(negedge clk);
   endtask

   task automatic check_slots(input string tag, input int e0, input int e1, input int e2, input int e3);
      int exp_v [4];
      exp_v = '{e0, e1, e2, e3};
      for (int k = 0; k < 4; k++)
         check_val($sformatf("%s_slot%0d", tag, k), ch_data1[k*12 +: 12], exp_v[k]);
   endtask

   task automatic check_reqs(input string tag, input int n, input logic [7:0] a0, input logic [7:0] a1,
                             input logic [7:0] a2, input logic [7:0] a3);
      logic [7:0] exp_a [4];
      exp_a = '{a0, a1, a2, a3};
      check_val({tag, "_nreq"}, req_log.size(), n);
      for (int k = 0; k < n; k++)
         check_val($sformatf("%s_addr%0d", tag, k), (k < req_log.size()) ? req_log[k] : 8'hFF, exp_a[k]);
   endtask

   // Overrun scenario bookkeeping for instance 2.
   int         first_rise, second_rise, fd2_t;
   bit         prev2;
   logic       o15, o16;
   logic [7:0] q2 [$];
   logic [7:0] exp_addr [4];
   bit         req_seen;

   initial begin
      rst1 = 1'b1; rst2 = 1'b1;
      enable1 = 1'b0; mask1 = 4'h0;
      enable2 = 1'b1; mask2 = 4'hF;
      code_tab = '{12'd0, 12'd1000, 12'd2048, 12'd4095};
      exp_addr = '{8'h10, 8'h20, 8'h40, 8'h80};
      first_rise = -1; second_rise = -1; fd2_t = -1; prev2 = 1'b0; o15 = 1'bx; o16 = 1'bx;
      repeat (3) @(negedge clk);

      // Reset state
      check_val("rst_busy", busy1, 0);
      check_val("rst_addr", adc_addr1, 8'h10);
      check_val("rst_req", adc_req1, 0);
      check_val("rst_data", ch_data1, 0);
      check_val("rst_fresh", ch_fresh1, 0);
      check_val("rst_fdone", frame_done1, 0);
      check_val("rst_ovr", overrun1, 0);
      check_val("rst_tmo", timeout1, 0);

      // Overrun: PERIOD=8, 9 cycles per channel. Cycle 0 is this negedge.
      rst2 = 1'b0;
      for (int t = 1; t <= 50; t++) begin
         @(negedge clk);
         if (busy2 && !prev2) begin
            if (first_rise < 0) first_rise = t;
            else if (second_rise < 0) second_rise = t;
         end
         prev2 = busy2;
         if (frame_done2 && fd2_t < 0) fd2_t = t;
         if (adc_req2 && fd2_t < 0) q2.push_back(adc_addr2);
         if (t == 15) o15 = overrun2;
         if (t == 16) o16 = overrun2;
      end
      check_val("ovr_first_start", first_rise, 8);
      check_val("ovr_frame_done", fd2_t, 44);
      check_val("ovr_next_start", second_rise, 48);
      check_val("ovr_flag_before", o15, 0);
      check_val("ovr_flag_after", o16, 1);
      check_val("ovr_nreq", q2.size(), 4);
      for (int k = 0; k < 4; k++)
         check_val($sformatf("ovr_addr%0d", k), (k < q2.size()) ? q2[k] : 8'hFF, exp_addr[k]);
      rst2 = 1'b1;

      // Full scan, all channels
      clear_log();
      enable1 = 1'b1; mask1 = 4'hF;
      rst1 = 1'b0;
      wait_frame(120, "t1_frame_seen");
      enable1 = 1'b0;
      check_slots("t1", 0, 805, 1649, 3299);
      check_val("t1_fresh", ch_fresh1, 4'hF);
      check_reqs("t1", 4, 8'h10, 8'h20, 8'h40, 8'h80);
      check_val("t1_nframe", fd_cnt, 1);
      check_val("t1_frame_len", fd_cyc - rise_cyc, 28);

      // enable=0 across a start event
      clear_log();
      repeat (45) @(negedge clk);
      check_val("t2_nreq", req_log.size(), 0);
      check_val("t2_nframe", fd_cnt, 0);
      check_val("t2_busy", busy_seen, 0);

      // mask=0 across a start event
      enable1 = 1'b1; mask1 = 4'h0;
      clear_log();
      repeat (45) @(negedge clk);
      enable1 = 1'b0;
      check_val("t3_nreq", req_log.size(), 0);
      check_val("t3_nframe", fd_cnt, 0);
      check_val("t3_busy", busy_seen, 0);

      // Partial mask 1010, new codes on channels 1 and 3
      code_tab[1] = 12'd4000;
      code_tab[3] = 12'd100;
      mask1 = 4'hA;
      clear_log();
      enable1 = 1'b1;
      wait_frame(100, "t4_frame_seen");
      enable1 = 1'b0;
      check_slots("t4", 0, 3222, 1649, 80);
      check_val("t4_fresh", ch_fresh1, 4'hA);
      check_reqs("t4", 2, 8'h20, 8'h80, 8'h00, 8'h00);
      check_val("t4_nframe", fd_cnt, 1);
      check_val("t4_frame_len", fd_cyc - rise_cyc, 14);

      // Channel 2 never answers: timeout, channel 3 still converted
      code_tab = '{12'd1000, 12'd2048, 12'd0, 12'd4095};
      noans_ch = 2;
      mask1 = 4'hF;
      check_val("t5_tmo_before", timeout1, 0);
      clear_log();
      enable1 = 1'b1;
      wait_frame(100, "t5_frame_seen");
      enable1 = 1'b0;
      check_val("t5_tmo_after", timeout1, 1);
      check_slots("t5", 805, 1649, 1649, 3299);
      check_val("t5_fresh", ch_fresh1, 4'hB);
      check_reqs("t5", 4, 8'h10, 8'h20, 8'h40, 8'h80);
      check_val("t5_nframe", fd_cnt, 1);
      check_val("t5_frame_len", fd_cyc - rise_cyc, 31);
      check_val("t5_ovr", overrun1, 0);

      // Reset during WAIT; the pending ADC answer must be ignored
      noans_ch = -1;
      enable1 = 1'b1;
      req_seen = 1'b0;
      for (int i = 0; i < 60 && !req_seen; i++) begin
         @(negedge clk);
         if (adc_req1) req_seen = 1'b1;
      end
      check_val("t6_req_seen", req_seen, 1);
      @(negedge clk);
      rst1 = 1'b1;
      @(negedge clk);
      check_val("t6_busy", busy1, 0);
      check_val("t6_data", ch_data1, 0);
      check_val("t6_addr", adc_addr1, 8'h10);
      check_val("t6_fresh", ch_fresh1, 0);
      check_val("t6_tmo", timeout1, 0);
      rst1 = 1'b0;
      enable1 = 1'b0;
      clear_log();
      repeat (6) @(negedge clk);
      check_val("t6_data_after", ch_data1, 0);
      check_val("t6_fresh_after", ch_fresh1, 0);
      check_val("t6_busy_after", busy_seen, 0);
      check_val("t6_nframe", fd_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
